// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline stage register.
//   Control-field bit positions of the EX/MEM control word, and the default
//   widths used by pipe_stage_reg and pipe_skid.
package pipe_pkg;

  // EX/MEM control-field bit indices
  localparam int MEMTOREG = 0;
  localparam int REGWRITE = 1;
  localparam int MEMWRITE = 2;

  // Default widths: 3 control bits, 2x32-bit operands + 5-bit register address
  localparam int CTRL_W_DEF = 3;
  localparam int DATA_W_DEF = 69;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_skid.sv
// pipe_skid -- one-entry skid buffer: payload storage plus a valid flag.
//   clk, rst_n  : clock, async active-low reset (clears the valid flag only)
//   load        : capture in_ctrl/in_data and mark the entry valid
//   clr         : empty the entry (wins over load)
//   vld         : entry holds a beat (registered)
//   ctrl, data  : held payload
module pipe_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (clr)       vld_d = 1'b0;
    else if (load) vld_d = 1'b1;
    if (load) begin
      ctrl_d = in_ctrl;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= vld_d;
  end

  // Payload is only meaningful under vld_q, so it carries no reset.
  always_ff @(posedge clk) begin
    ctrl_q <= ctrl_d;
    data_q <= data_d;
  end

  assign vld  = vld_q;
  assign ctrl = ctrl_q;
  assign data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline stage register (EX/MEM style).
//   clk, rst_n          : clock, async active-low reset
//   flush               : drop held and incoming beats
//   in_valid/in_ready   : upstream handshake, in_ctrl/in_data payload
//   out_valid/out_ready : downstream handshake, out_ctrl/out_data payload
//   stall_cnt           : saturating count of cycles with out_valid && !out_ready
// Build option PIPE_STAGE_REG_SKID_EN: adds a one-entry skid buffer so in_ready
// comes from a flop; otherwise in_ready = !out_valid || out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              slot_free;

  // Output register can take a new beat this edge.
  assign slot_free = !vld_q || out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              skid_vld, skid_load, skid_clr;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  pipe_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .clr     (skid_clr),
    .in_ctrl (in_ctrl),
    .in_data (in_data),
    .vld     (skid_vld),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

  assign in_ready = !skid_vld;

  // A parked beat always drains ahead of new input; while it is parked
  // in_ready is low, so no new beat competes for the output slot.
  always_comb begin
    vld_d     = vld_q;
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      vld_d    = 1'b0;
      ctrl_d   = '0;
      skid_clr = 1'b1;
    end else if (slot_free) begin
      if (skid_vld) begin
        vld_d    = 1'b1;
        ctrl_d   = skid_ctrl;
        data_d   = skid_data;
        skid_clr = 1'b1;
      end else begin
        vld_d  = in_valid;
        ctrl_d = in_valid ? in_ctrl : '0;
        if (in_valid) data_d = in_data;
      end
    end else if (in_valid && in_ready) begin
      skid_load = 1'b1;
    end
  end
`else
  assign in_ready = slot_free;

  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (flush) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
    end else if (slot_free) begin
      vld_d  = in_valid;
      ctrl_d = in_valid ? in_ctrl : '0;
      if (in_valid) data_d = in_data;
    end
  end
`endif

  // Stall counter saturates and ignores flush.
  always_comb begin
    cnt_d = cnt_q;
    if (vld_q && !out_ready && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_valid = vld_q;
  // Bubbles present a zero control word so they never write.
  assign out_ctrl  = vld_q ? ctrl_q : '0;
  assign out_data  = data_q;
  assign stall_cnt = cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 3, meaning the control-field width (e.g. MemtoReg, RegWrite, MemWrite); these bits are cleared on reset and flush.
REQ-002 The block SHALL have parameter DATA_W, default 69, meaning the data-field width (two 32-bit operands plus a 5-bit register address); these bits are not cleared.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port flush, input, 1 bit: discards all held and incoming beats.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009 The block SHALL have ports in_ctrl (input, CTRL_W bits) and in_data (input, DATA_W bits): the upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: downstream beat present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts; low means the stage is stalled.
REQ-012 The block SHALL have ports out_ctrl (output, CTRL_W bits) and out_data (output, DATA_W bits): the registered payload.
REQ-013 The block SHALL have port stall_cnt, output, CNT_W bits: count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 A beat SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-015 The block SHALL present an accepted beat on out_* at the next rising edge (1-cycle latency); there SHALL be no combinational path from in_* to out_*.
REQ-016 While out_valid=1 and out_ready=0, out_valid, out_ctrl and out_data SHALL hold stable.
REQ-017 If flush=1 at an edge, out_valid and all held valid flags SHALL clear and out_ctrl SHALL become 0; an incoming beat in that cycle SHALL be dropped; flush SHALL take priority over load.
REQ-018 The block SHALL force out_ctrl to 0 whenever out_valid=0, so that a bubble never writes.
REQ-019 Simultaneous out-transfer and in-transfer SHALL replace the held beat with no bubble, sustaining one beat per cycle.
REQ-020 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at all-ones, and be unaffected by flush.

Reset
REQ-021 While rst_n=0 the block SHALL drive out_valid=0, out_ctrl=0, stall_cnt=0 and all internal valid flags to 0 asynchronously; out_data SHALL be don't-care.
REQ-022 The block SHALL first accept a beat on the first rising edge after rst_n deasserts, and SHALL drop any beat in flight at reset assertion.

Configuration
REQ-023 With macro PIPE_STAGE_REG_SKID_EN defined, the block SHALL contain a 1-entry skid buffer and drive in_ready from a register, equal to the inverse of skid_valid.
REQ-024 With PIPE_STAGE_REG_SKID_EN defined, a beat accepted while the output is stalled SHALL park in the skid entry and move to the output on the first cycle with out_ready=1, preserving order; flush SHALL clear the skid entry as well.
REQ-025 Without PIPE_STAGE_REG_SKID_EN, the block SHALL drive in_ready = !out_valid || out_ready combinationally and SHALL hold no skid storage.

Structure
REQ-026 The shared package pipe_pkg SHALL hold the EX/MEM control-field bit indices (MEMTOREG, REGWRITE, MEMWRITE) and default widths as localparams.
REQ-027 The skid entry SHALL be the sub-module pipe_skid (storage plus valid flag), instantiated only under PIPE_STAGE_REG_SKID_EN.

Verification
REQ-028 Streaming: in_valid=1 with data 0x1..0x8 and out_ready=1 -> out_data shows 0x1..0x8 on consecutive cycles, starting 1 cycle after the first beat, with no gaps.
REQ-029 Stall: out_ready=0 for 4 cycles while holding 0x5 -> out_data stays 0x5 and stall_cnt increments 0->4; in SKID mode exactly one extra beat (0x6) is accepted before in_ready falls.
REQ-030 Flush: flush=1 while holding ctrl=3'b111 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, and the incoming beat never appears.
REQ-031 Async reset: drop rst_n mid-stream between edges -> out_valid=0 and stall_cnt=0 immediately; the first beat after release appears 1 cycle after acceptance.
REQ-032 Saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15 and holds at 15.
